// File: rtl/axi4_frame_writer.sv
// Packs 16-bit pixels into 64-bit words, buffers them in a first-word-fall-through FIFO and
// drains full bursts of BURST_LEN beats to DDR as AXI4 INCR writes at base + running offset.
module axi4_frame_writer #(
    parameter int unsigned AXI_ADDR_WIDTH   = 32,
    parameter int unsigned AXI_DATA_WIDTH   = 64,
    parameter int unsigned BURST_LEN        = 4,
    parameter int unsigned FIFO_DEPTH       = 64,
    parameter int unsigned PROG_FULL_THRESH = 48
) (
    input  logic                        clk_100Mhz,
    input  logic                        rst,
    input  logic [15:0]                 mixed_data,
    input  logic                        pixel_valid,
    input  logic                        frame_done,
    input  logic [AXI_ADDR_WIDTH-1:0]   FRAME_BASE_ADDR,
    output logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
    output logic                        AWVALID,
    input  logic                        AWREADY,
    output logic [7:0]                  AWLEN,
    output logic [2:0]                  AWSIZE,
    output logic [1:0]                  AWBURST,
    output logic [3:0]                  AWCACHE,
    output logic [2:0]                  AWPROT,
    output logic [AXI_DATA_WIDTH-1:0]   WDATA,
    output logic                        WVALID,
    output logic                        WLAST,
    output logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                        WREADY,
    input  logic                        BVALID,
    input  logic [1:0]                  BRESP,
    output logic                        BREADY,
    output logic                        o_prog_full,
    output logic [1:0]                  state,
    output logic [AXI_ADDR_WIDTH-1:0]   ADDR_OFFSET
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [7:0] LastBeat = 8'(BURST_LEN - 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] BurstBytes = AXI_ADDR_WIDTH'(BURST_LEN * 8);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2,
        StResp = 2'd3
    } state_e;

    // ---------------- packer ----------------
    logic [1:0]  pix_cnt_q;
    logic [47:0] pack_q;
    logic        word_done;

    // A pixel coinciding with frame_done belongs to the discarded partial word.
    assign word_done = pixel_valid && !frame_done && (pix_cnt_q == 2'd3);

    always_ff @(posedge clk_100Mhz or negedge rst) begin
        if (!rst) begin
            pix_cnt_q <= '0;
            pack_q    <= '0;
        end else if (frame_done) begin
            pix_cnt_q <= '0;
        end else if (pixel_valid) begin
            pix_cnt_q <= pix_cnt_q + 2'd1;
            pack_q    <= {mixed_data, pack_q[47:16]};
        end
    end

    // ---------------- FIFO ----------------
    logic [AXI_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [CntW-1:0]           wr_ptr_q, rd_ptr_q, count;
    logic                      push, pop, full;

    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (count == CntW'(FIFO_DEPTH));
    assign push  = word_done && !full;
    assign pop   = WVALID && WREADY;

    always_ff @(posedge clk_100Mhz) begin
        if (push) mem_q[wr_ptr_q[PtrW-1:0]] <= {mixed_data, pack_q};
    end

    always_ff @(posedge clk_100Mhz or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + CntW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + CntW'(1);
        end
    end

    assign WDATA       = mem_q[rd_ptr_q[PtrW-1:0]];
    assign o_prog_full = (count >= CntW'(PROG_FULL_THRESH));

    // ---------------- burst FSM ----------------
    state_e                    state_q, state_d;
    logic                      awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                      wlast_q, wlast_d, bready_q, bready_d, pend_q, pend_d;
    logic [7:0]                beat_q, beat_d;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d, offset_q, offset_d;

    always_ff @(posedge clk_100Mhz or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            pend_q    <= 1'b0;
            beat_q    <= '0;
            awaddr_q  <= '0;
            offset_q  <= '0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            wlast_q   <= wlast_d;
            bready_q  <= bready_d;
            pend_q    <= pend_d;
            beat_q    <= beat_d;
            awaddr_q  <= awaddr_d;
            offset_q  <= offset_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        wlast_d   = wlast_q;
        bready_d  = bready_q;
        beat_d    = beat_q;
        awaddr_d  = awaddr_q;
        offset_d  = offset_q;
        pend_d    = pend_q || frame_done;
        unique case (state_q)
            StIdle: begin
                // A pending frame restart takes effect before the next address is formed.
                if (pend_d) begin
                    offset_d = '0;
                    pend_d   = 1'b0;
                end
                if (count >= CntW'(BURST_LEN)) begin
                    awaddr_d  = FRAME_BASE_ADDR + offset_d;
                    awvalid_d = 1'b1;
                    state_d   = StAddr;
                end
            end
            StAddr: begin
                if (AWREADY) begin
                    awvalid_d = 1'b0;
                    beat_d    = '0;
                    wvalid_d  = 1'b1;
                    wlast_d   = (LastBeat == 8'd0);
                    state_d   = StData;
                end
            end
            StData: begin
                if (WREADY) begin
                    if (wlast_q) begin
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                        bready_d = 1'b1;
                        state_d  = StResp;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        wlast_d = (beat_d == LastBeat);
                    end
                end
            end
            StResp: begin
                if (BVALID) begin
                    bready_d = 1'b0;
                    offset_d = pend_d ? '0 : offset_q + BurstBytes;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Every response, error or not, retires the burst.
    logic unused_bresp;
    assign unused_bresp = ^BRESP;

    assign AWADDR      = awaddr_q;
    assign AWVALID     = awvalid_q;
    assign WVALID      = wvalid_q;
    assign WLAST       = wlast_q;
    assign BREADY      = bready_q;
    assign state       = state_q;
    assign ADDR_OFFSET = offset_q;
    assign AWLEN       = LastBeat;
    assign AWSIZE      = 3'b011;
    assign AWBURST     = 2'b01;
    assign AWCACHE     = 4'b0011;
    assign AWPROT      = 3'b000;
    assign WSTRB       = '1;
endmodule

// File: tb/tb_axi4_frame_writer.sv
// Self-checking bench for axi4_frame_writer: reset/packing tables, hand-written burst
// sequences and a randomized run against a queue-level model of the pixel and burst stream.
module tb_axi4_frame_writer;
    localparam int BL    = 4;
    localparam int DEPTH = 64;
    localparam int THR   = 48;

    logic        clk_100Mhz = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] mixed_data = '0;
    logic        pixel_valid = 1'b0, frame_done = 1'b0;
    logic [31:0] FRAME_BASE_ADDR = '0;
    logic [31:0] AWADDR, ADDR_OFFSET;
    logic        AWVALID, AWREADY = 1'b0;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE, AWPROT;
    logic [1:0]  AWBURST, BRESP = 2'b00, state;
    logic [3:0]  AWCACHE;
    logic [63:0] WDATA;
    logic        WVALID, WLAST, WREADY = 1'b0;
    logic [7:0]  WSTRB;
    logic        BVALID = 1'b0, BREADY, o_prog_full;

    axi4_frame_writer dut (
        .clk_100Mhz     (clk_100Mhz),
        .rst            (rst),
        .mixed_data     (mixed_data),
        .pixel_valid    (pixel_valid),
        .frame_done     (frame_done),
        .FRAME_BASE_ADDR(FRAME_BASE_ADDR),
        .AWADDR         (AWADDR),
        .AWVALID        (AWVALID),
        .AWREADY        (AWREADY),
        .AWLEN          (AWLEN),
        .AWSIZE         (AWSIZE),
        .AWBURST        (AWBURST),
        .AWCACHE        (AWCACHE),
        .AWPROT         (AWPROT),
        .WDATA          (WDATA),
        .WVALID         (WVALID),
        .WLAST          (WLAST),
        .WSTRB          (WSTRB),
        .WREADY         (WREADY),
        .BVALID         (BVALID),
        .BRESP          (BRESP),
        .BREADY         (BREADY),
        .o_prog_full    (o_prog_full),
        .state          (state),
        .ADDR_OFFSET    (ADDR_OFFSET)
    );

    always #5 clk_100Mhz = ~clk_100Mhz;

    int tests = 0;
    int fails = 0;

    // Reference model: pending pixels, queued words, beat position and expected offset.
    logic [15:0] pq[$];
    logic [63:0] mq[$];
    int          beat_m = 0;
    logic [31:0] exp_off = '0;
    bit          zpend = 1'b0;

    typedef struct {
        string       nm;
        int          sel;
        logic [63:0] exp;
    } rst_vec_t;

    typedef struct {
        logic [15:0] p[4];
        logic [63:0] w;
    } quad_t;

    rst_vec_t rtab[14];
    quad_t    qtab[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] get_out(input int sel);
        case (sel)
            0:  return 64'(AWVALID);
            1:  return 64'(WVALID);
            2:  return 64'(WLAST);
            3:  return 64'(BREADY);
            4:  return 64'(AWADDR);
            5:  return 64'(ADDR_OFFSET);
            6:  return 64'(state);
            7:  return 64'(o_prog_full);
            8:  return 64'(AWLEN);
            9:  return 64'(AWSIZE);
            10: return 64'(AWBURST);
            11: return 64'(AWCACHE);
            12: return 64'(AWPROT);
            default: return 64'(WSTRB);
        endcase
    endfunction

    // Observe the pre-edge handshakes, update the model, then advance one clock.
    task automatic cycle();
        bit          push = 1'b0;
        bit          full;
        logic [63:0] w = '0;
        chk("prog_full", 64'(o_prog_full), 64'(mq.size() >= THR));
        if (AWVALID && AWREADY) begin
            if (zpend) begin
                exp_off = '0;
                zpend   = 1'b0;
            end
            chk("awaddr", 64'(AWADDR), 64'(FRAME_BASE_ADDR + exp_off));
        end
        if (WVALID && WREADY) begin
            if (mq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL w_underflow: beat accepted with %0d words expected", mq.size());
            end else begin
                chk("wdata", WDATA, mq[0]);
                chk("wlast", 64'(WLAST), 64'(beat_m == BL - 1));
            end
            beat_m = (beat_m + 1) % BL;
        end
        if (BVALID && BREADY) exp_off = frame_done ? 32'h0 : exp_off + 32'(BL * 8);
        if (frame_done) begin
            pq.delete();
            zpend = 1'b1;
        end else if (pixel_valid) begin
            pq.push_back(mixed_data);
            if (pq.size() == 4) begin
                w = {pq[3], pq[2], pq[1], pq[0]};
                pq.delete();
                push = 1'b1;
            end
        end
        full = (mq.size() == DEPTH);
        if (WVALID && WREADY && mq.size() > 0) void'(mq.pop_front());
        if (push && !full) mq.push_back(w);
        @(posedge clk_100Mhz);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string nm);
        int n = 0;
        while (state !== s && n < budget) begin
            cycle();
            n++;
        end
        chk(nm, 64'(state), 64'(s));
    endtask

    task automatic push_pix(input logic [15:0] d);
        pixel_valid = 1'b1;
        mixed_data  = d;
        cycle();
        pixel_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        pixel_valid = 1'b0;
        frame_done  = 1'b0;
        AWREADY     = 1'b1;
        WREADY      = 1'b1;
        BVALID      = 1'b1;
        while (!(state == 2'd0 && mq.size() < BL) && n < 2000) begin
            cycle();
            n++;
        end
        chk(nm, 64'(state == 2'd0 && mq.size() < BL), 64'd1);
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
    endtask

    initial begin
        logic [63:0] wexp [7];
        int          acc;
        wexp = '{64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005, 64'h000c_000b_000a_0009,
                 64'h0010_000f_000e_000d, 64'h0014_0013_0012_0011, 64'h0018_0017_0016_0015,
                 64'h001c_001b_001a_0019};
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < 4; k++) qtab[i].p[k] = 16'(4 * i + k + 1);
            qtab[i].w = wexp[i];
        end
        rtab[0]  = '{"rst_awvalid", 0, 64'h0};
        rtab[1]  = '{"rst_wvalid", 1, 64'h0};
        rtab[2]  = '{"rst_wlast", 2, 64'h0};
        rtab[3]  = '{"rst_bready", 3, 64'h0};
        rtab[4]  = '{"rst_awaddr", 4, 64'h0};
        rtab[5]  = '{"rst_offset", 5, 64'h0};
        rtab[6]  = '{"rst_state", 6, 64'h0};
        rtab[7]  = '{"rst_prog_full", 7, 64'h0};
        rtab[8]  = '{"awlen", 8, 64'h3};
        rtab[9]  = '{"awsize", 9, 64'h3};
        rtab[10] = '{"awburst", 10, 64'h1};
        rtab[11] = '{"awcache", 11, 64'h3};
        rtab[12] = '{"awprot", 12, 64'h0};
        rtab[13] = '{"wstrb", 13, 64'hff};

        // T1: reset values, then idle with no pixels
        repeat (3) @(posedge clk_100Mhz);
        #1;
        foreach (rtab[i]) chk(rtab[i].nm, get_out(rtab[i].sel), rtab[i].exp);
        rst = 1'b1;
        FRAME_BASE_ADDR = 32'h1000_0000;
        repeat (5) cycle();
        chk("idle_awvalid", 64'(AWVALID), 64'h0);
        chk("idle_state", 64'(state), 64'h0);

        // T2: 30 pixels with the slave stalled
        foreach (qtab[i]) for (int k = 0; k < 4; k++) push_pix(qtab[i].p[k]);
        push_pix(16'd29);
        push_pix(16'd30);
        chk("t2_awvalid", 64'(AWVALID), 64'h1);
        chk("t2_awaddr", 64'(AWADDR), 64'h1000_0000);
        chk("t2_awlen", 64'(AWLEN), 64'h3);
        chk("t2_state", 64'(state), 64'h1);

        // T3: AW held off, then a single-cycle AWREADY pulse
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("t3_awvalid_hold", 64'(AWVALID), 64'h1);
            chk("t3_awaddr_hold", 64'(AWADDR), 64'h1000_0000);
        end
        AWREADY = 1'b1;
        cycle();
        AWREADY = 1'b0;
        chk("t3_state", 64'(state), 64'h2);
        chk("t3_awvalid_low", 64'(AWVALID), 64'h0);
        chk("t3_wvalid", 64'(WVALID), 64'h1);

        // T4: WREADY toggling every cycle
        acc = 0;
        for (int n = 0; n < 40 && state == 2'd2; n++) begin
            WREADY = (n % 2 == 0);
            if (WVALID && WREADY && acc < 7) begin
                chk("t4_beat", WDATA, qtab[acc].w);
                acc++;
            end
            cycle();
        end
        WREADY = 1'b0;
        chk("t4_pops", 64'(acc), 64'd4);
        chk("t4_state", 64'(state), 64'h3);
        chk("t4_bready", 64'(BREADY), 64'h1);
        chk("t4_wvalid_low", 64'(WVALID), 64'h0);

        // T5: response, then a second burst at the next offset
        BVALID = 1'b1;
        cycle();
        BVALID = 1'b0;
        chk("t5_offset", 64'(ADDR_OFFSET), 64'h20);
        chk("t5_state", 64'(state), 64'h0);
        repeat (3) cycle();
        chk("t5_three_left", 64'(AWVALID), 64'h0);
        push_pix(16'd31);
        push_pix(16'd32);
        wait_state(2'd1, 10, "t5_addr");
        chk("t5_awaddr2", 64'(AWADDR), 64'h1000_0020);
        drain("t5_drain");
        chk("t5_offset2", 64'(ADDR_OFFSET), 64'h40);

        // T6: frame_done discards a partial word and restarts the offset
        for (int i = 0; i < 6; i++) push_pix(16'($urandom));
        frame_done = 1'b1;
        cycle();
        frame_done = 1'b0;
        cycle();
        chk("t6_offset_zero", 64'(ADDR_OFFSET), 64'h0);
        for (int n = 0; n < 1000 && mq.size() < THR - 1; n++) push_pix(16'($urandom));
        cycle();
        chk("t6_below_thresh", 64'(o_prog_full), 64'h0);
        for (int i = 0; i < 4; i++) push_pix(16'($urandom));
        cycle();
        chk("t6_prog_full", 64'(o_prog_full), 64'h1);
        for (int i = 0; i < 22 * 4; i++) push_pix(16'($urandom));
        cycle();
        chk("t6_full_count", 64'(mq.size()), 64'(DEPTH));
        drain("t6_drain");

        // Randomized traffic with random back-pressure
        FRAME_BASE_ADDR = $urandom & 32'hffff_fff8;
        for (int n = 0; n < 3000; n++) begin
            pixel_valid = ($urandom_range(0, 3) != 0);
            mixed_data  = 16'($urandom);
            AWREADY     = ($urandom_range(0, 2) == 0);
            WREADY      = ($urandom_range(0, 1) == 0);
            BVALID      = ($urandom_range(0, 3) == 0);
            BRESP       = 2'($urandom);
            cycle();
        end
        drain("rand_drain");

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 16; i++) push_pix(16'($urandom));
        AWREADY = 1'b1;
        wait_state(2'd2, 20, "mid_reset_data");
        AWREADY = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_reset_wvalid", 64'(WVALID), 64'h0);
        chk("mid_reset_awvalid", 64'(AWVALID), 64'h0);
        chk("mid_reset_bready", 64'(BREADY), 64'h0);
        chk("mid_reset_state", 64'(state), 64'h0);
        chk("mid_reset_offset", 64'(ADDR_OFFSET), 64'h0);
        chk("mid_reset_prog_full", 64'(o_prog_full), 64'h0);
        mq.delete();
        pq.delete();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
